sync_fifo_param: RTL and testbench

Parametrised synchronous FIFO, the next-generation buffer for the verification environment's DUT library. It has configurable data width and depth. It supports simultaneous read and write in one cycle, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, a synchronous flush, and an optional first-word-fall-through (FWFT) read mode. It sits between a single-clock producer and consumer on the `fifo_if`-style handshake: `wr_en`/`rd_en` strobes, `full`/`empty` status.

---
 rtl/sync_fifo_param.sv | 157 +++++++++++++++
 tb/tb_sync_fifo_param.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parametrised single-clock FIFO with thresholds, sticky errors, flush and FWFT
//
// Purpose:
//   Single-clock FIFO between a producer and a consumer. Depth is a power of
//   two. Occupancy is kept in a dedicated count register, and every status
//   flag decodes from that register alone, so pointer wrap never affects
//   full/empty.
//
// Parameters:
//   WIDTH     data word width in bits (>= 1)
//   DEPTH     number of entries, power of two (>= 4)
//   AF_LEVEL  almost_full when count >= AF_LEVEL (1..DEPTH)
//   AE_LEVEL  almost_empty when count <= AE_LEVEL (0..DEPTH-1)
//   FWFT      0: registered read data, 1: head word shown combinationally
//
// Ports:
//   clk           clock, rising edge
//   rst_n         asynchronous active-low reset
//   clear         synchronous flush, overrides wr_en/rd_en
//   wr_en         write request, accepted when not full
//   data_in       write data
//   rd_en         read request / FWFT pop, accepted when not empty
//   data_out      read data (FWFT: head word, undefined while empty)
//   full          count == DEPTH
//   empty         count == 0
//   almost_full   count >= AF_LEVEL
//   almost_empty  count <= AE_LEVEL
//   count         occupancy 0..DEPTH
//   overflow      sticky, write attempted while full
//   underflow     sticky, read attempted while empty

module sync_fifo_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         data_out,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_next;
    logic          overflow_q;
    logic          underflow_q;

    logic          wr_acc;
    logic          rd_acc;

    // Status flags come from the count register only.
    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // Acceptance uses the flags at the start of the cycle, so a full FIFO
    // with both strobes high only reads and an empty one only writes.
    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    always_comb begin
        count_next = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_next = count_q + CW'(1);
            2'b01:   count_next = count_q - CW'(1);
            default: count_next = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (clear) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count_q <= count_next;
            // Flagged whenever the strobe meets the blocking flag, even if
            // the opposite side is accepted in the same cycle.
            if (wr_en && full) begin
                overflow_q <= 1'b1;
            end
            if (rd_en && empty) begin
                underflow_q <= 1'b1;
            end
        end
    end

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr_acc && !clear && rst_n) begin
            mem[wr_ptr] <= data_in;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is visible as soon as it has been written.
            assign data_out = mem[rd_ptr];
        end else begin : g_reg
            logic [WIDTH-1:0] data_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_q <= '0;
                end else if (clear) begin
                    data_q <= '0;
                end else if (rd_acc) begin
                    data_q <= mem[rd_ptr];
                end
            end

            assign data_out = data_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - directed self-checking bench for sync_fifo_param

module tb_sync_fifo_param;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;

    logic       f_wr_en;
    logic       f_rd_en;
    logic [7:0] f_data_in;
    logic [7:0] f_data_out;
    logic       f_full;
    logic       f_empty;
    logic       f_almost_full;
    logic       f_almost_empty;
    logic [4:0] f_count;
    logic       f_overflow;
    logic       f_underflow;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] q[$];
    logic [7:0] exp_d;

    sync_fifo_param #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (clear),
        .wr_en        (wr_en),
        .data_in      (data_in),
        .rd_en        (rd_en),
        .data_out     (data_out),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    sync_fifo_param #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1)) u_fwft (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (clear),
        .wr_en        (f_wr_en),
        .data_in      (f_data_in),
        .rd_en        (f_rd_en),
        .data_out     (f_data_out),
        .full         (f_full),
        .empty        (f_empty),
        .almost_full  (f_almost_full),
        .almost_empty (f_almost_empty),
        .count        (f_count),
        .overflow     (f_overflow),
        .underflow    (f_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        clear     = 1'b0;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        data_in   = 8'h00;
        f_wr_en   = 1'b0;
        f_rd_en   = 1'b0;
        f_data_in = 8'h00;
        #1;

        // Reset state
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_ae", almost_empty, 1);
        chk("rst_full", full, 0);
        chk("rst_af", almost_full, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_udf", underflow, 0);
        chk("rst_dout", data_out, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Fill with 0x01..0x10
        for (int i = 1; i <= 16; i++) begin
            wr_en   = 1'b1;
            data_in = 8'(i);
            tick();
            chk("fill_count", count, i);
            chk("fill_full", full, (i == 16) ? 1 : 0);
            chk("fill_af", almost_full, (i >= 14) ? 1 : 0);
            chk("fill_ae", almost_empty, (i <= 2) ? 1 : 0);
            chk("fill_empty", empty, 0);
        end
        // 17th write: rejected, overflow latched
        data_in = 8'hEE;
        tick();
        wr_en = 1'b0;
        chk("ovf_set", overflow, 1);
        chk("ovf_count", count, 16);
        chk("ovf_udf", underflow, 0);

        // Drain; data must be the original 0x01..0x10
        for (int k = 1; k <= 16; k++) begin
            rd_en = 1'b1;
            tick();
            chk("drain_dout", data_out, k);
            chk("drain_count", count, 16 - k);
            chk("drain_ae", almost_empty, ((16 - k) <= 2) ? 1 : 0);
        end
        chk("drain_empty", empty, 1);
        // Extra read: underflow, data held
        tick();
        rd_en = 1'b0;
        chk("udf_set", underflow, 1);
        chk("udf_dout_hold", data_out, 8'h10);
        chk("udf_count", count, 0);

        // Clear zeroes flags and registered data
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_ovf", overflow, 0);
        chk("clr_udf", underflow, 0);
        chk("clr_dout", data_out, 0);
        chk("clr_empty", empty, 1);

        // Fill to 8, then stream 40 cycles with both strobes high
        for (int i = 0; i < 8; i++) begin
            wr_en   = 1'b1;
            data_in = 8'h30 + 8'(i);
            q.push_back(data_in);
            tick();
        end
        chk("stream_start_count", count, 8);
        rd_en = 1'b1;
        for (int j = 0; j < 40; j++) begin
            data_in = 8'h40 + 8'(j);
            q.push_back(data_in);
            tick();
            exp_d = q.pop_front();
            chk("stream_dout", data_out, exp_d);
            chk("stream_count", count, 8);
        end
        rd_en = 1'b0;
        chk("stream_ovf", overflow, 0);
        chk("stream_udf", underflow, 0);

        // Top up to full
        for (int i = 0; i < 8; i++) begin
            data_in = 8'h80 + 8'(i);
            q.push_back(data_in);
            tick();
        end
        chk("topup_full", full, 1);
        // Full with both high: read only, overflow flagged by the write strobe
        data_in = 8'hDD;
        rd_en   = 1'b1;
        tick();
        wr_en = 1'b0;
        exp_d = q.pop_front();
        chk("fullboth_count", count, 15);
        chk("fullboth_dout", data_out, exp_d);
        chk("fullboth_ovf", overflow, 1);

        // Drain the remaining 15
        for (int k = 0; k < 15; k++) begin
            tick();
            exp_d = q.pop_front();
            chk("drain2_dout", data_out, exp_d);
        end
        chk("drain2_empty", empty, 1);
        // Empty with both high: write only
        wr_en   = 1'b1;
        data_in = 8'h77;
        tick();
        rd_en = 1'b0;
        chk("emptyboth_count", count, 1);
        chk("emptyboth_udf", underflow, 1);
        chk("emptyboth_dout_hold", data_out, exp_d);

        // Bring to 5 entries with overflow still set, then clear during a write
        for (int i = 0; i < 4; i++) begin
            data_in = 8'h90 + 8'(i);
            tick();
        end
        chk("pre_clr_count", count, 5);
        chk("pre_clr_ovf", overflow, 1);
        data_in = 8'h99;
        clear   = 1'b1;
        tick();
        clear = 1'b0;
        wr_en = 1'b0;
        chk("clrwr_count", count, 0);
        chk("clrwr_ovf", overflow, 0);
        chk("clrwr_udf", underflow, 0);
        chk("clrwr_empty", empty, 1);
        tick();
        chk("clrwr_count_hold", count, 0);

        // FWFT instance
        f_wr_en   = 1'b1;
        f_data_in = 8'hA5;
        tick();
        f_wr_en = 1'b0;
        chk("fwft_dout", f_data_out, 8'hA5);
        chk("fwft_empty0", f_empty, 0);
        chk("fwft_count1", f_count, 1);
        f_rd_en = 1'b1;
        tick();
        f_rd_en = 1'b0;
        chk("fwft_pop_empty", f_empty, 1);
        chk("fwft_pop_count", f_count, 0);
        f_wr_en   = 1'b1;
        f_data_in = 8'h3C;
        tick();
        f_data_in = 8'h5A;
        tick();
        f_wr_en = 1'b0;
        chk("fwft_head", f_data_out, 8'h3C);
        f_rd_en = 1'b1;
        tick();
        f_rd_en = 1'b0;
        chk("fwft_next", f_data_out, 8'h5A);
        chk("fwft_count", f_count, 1);

        // Asynchronous reset mid-write
        wr_en   = 1'b1;
        data_in = 8'h11;
        tick();
        data_in = 8'h22;
        tick();
        data_in = 8'h33;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("prerst_dout", data_out, 8'h11);
        chk("prerst_count", count, 2);
        wr_en   = 1'b1;
        data_in = 8'h44;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_count", count, 0);
        chk("arst_empty", empty, 1);
        chk("arst_ae", almost_empty, 1);
        chk("arst_full", full, 0);
        chk("arst_af", almost_full, 0);
        chk("arst_ovf", overflow, 0);
        chk("arst_udf", underflow, 0);
        chk("arst_dout", data_out, 0);
        chk("arst_fwft_count", f_count, 0);
        wr_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
